// File: rtl/avg_stream_pkg.sv
// Shared types and widths for the averaging datapath.
// Default sample/window sizes, window FSM encoding, fill width.
package avg_stream_pkg;

  localparam int W_DEF = 8;
  localparam int N_DEF = 8;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } win_state_t;

  // Width of a counter holding 0..n.
  function automatic int fc_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sample_shift_window.sv
// N-deep by W-bit shift register, newest sample in the LSBs.
// Ports: clk, clr (sync clear), shift, din, window_nxt (post-shift view).
module sample_shift_window #(
  parameter int W = 8,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           shift,
  input  logic [W-1:0]   din,
  output logic [N*W-1:0] window_nxt
);

  logic [N*W-1:0] window;

  // Combinational view of the window as it will be after a shift,
  // so a consumer can capture it on the same edge.
  generate
    if (N > 1) begin : g_deep
      assign window_nxt = {window[N*W-W-1:0], din};
    end else begin : g_single
      assign window_nxt = din;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      window <= '0;
    end else if (shift) begin
      window <= window_nxt;
    end
  end

endmodule

// File: rtl/sample_window_packer.sv
// Packs accepted samples into a sliding window and emits it every STRIDE.
// Ports: clk, rst (sync low), sample_*, flush, data_stream/stream_*, fill_count.
module sample_window_packer
  import avg_stream_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int N      = N_DEF,
  parameter int STRIDE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  input  logic                 flush,
  output logic [N*W-1:0]       data_stream,
  output logic                 stream_valid,
  input  logic                 stream_ready,
  output logic [fc_w(N)-1:0]   fill_count
);

  localparam int FW = fc_w(N);
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  win_state_t     state, state_d;
  logic [FW-1:0]  fill_d;
  logic [SW-1:0]  stride_cnt, stride_d;
  logic [N*W-1:0] win_nxt;
  logic           emit_next;
  logic           acc;
  logic           emit;
  logic           win_clr;

  assign emit_next = (state == FILL)
                   ? (fill_count == FW'(N - 1))
                   : (stride_cnt == SW'(STRIDE - 1));

  // Only the emitting sample is held off while a window is stalled,
  // so a pending window is never overwritten.
  assign sample_ready = !flush
                      & !(stream_valid & !stream_ready & emit_next);

  assign acc     = sample_valid & sample_ready;
  assign emit    = acc & emit_next;
  assign win_clr = !rst | flush;

  sample_shift_window #(
    .W (W),
    .N (N)
  ) u_win (
    .clk        (clk),
    .clr        (win_clr),
    .shift      (acc),
    .din        (sample_in),
    .window_nxt (win_nxt)
  );

  always_comb begin
    state_d  = state;
    fill_d   = fill_count;
    stride_d = stride_cnt;
    if (flush) begin
      state_d  = FILL;
      fill_d   = '0;
      stride_d = '0;
    end else if (acc) begin
      unique case (state)
        FILL: begin
          fill_d = fill_count + FW'(1);
          if (emit_next) begin
            state_d  = RUN;
            stride_d = '0;
          end
        end
        RUN: begin
          stride_d = emit_next ? '0 : stride_cnt + SW'(1);
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= FILL;
      fill_count   <= '0;
      stride_cnt   <= '0;
      data_stream  <= '0;
      stream_valid <= 1'b0;
    end else begin
      state      <= state_d;
      fill_count <= fill_d;
      stride_cnt <= stride_d;
      if (emit) begin
        data_stream  <= win_nxt;
        stream_valid <= 1'b1;
      end else if (stream_ready) begin
        stream_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_window_packer.sv
// Scoreboard bench: sliding (STRIDE=1) and block (STRIDE=8) packers.
// Windows are queued at stimulus time and checked on each handshake.
module tb_sample_window_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sv  [2];
  logic        fl  [2];
  logic        str [2];
  logic        sr  [2];
  logic        stv [2];
  logic [7:0]  si  [2];
  logic [63:0] ds  [2];
  logic [3:0]  fc  [2];

  int checks = 0;
  int errors = 0;
  int pops0  = 0;
  int pops1  = 0;
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];

  sample_window_packer #(.W(8), .N(8), .STRIDE(1)) u0 (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (si[0]),
    .sample_valid (sv[0]),
    .sample_ready (sr[0]),
    .flush        (fl[0]),
    .data_stream  (ds[0]),
    .stream_valid (stv[0]),
    .stream_ready (str[0]),
    .fill_count   (fc[0])
  );

  sample_window_packer #(.W(8), .N(8), .STRIDE(8)) u1 (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (si[1]),
    .sample_valid (sv[1]),
    .sample_ready (sr[1]),
    .flush        (fl[1]),
    .data_stream  (ds[1]),
    .stream_valid (stv[1]),
    .stream_ready (str[1]),
    .fill_count   (fc[1])
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input int d, input logic [7:0] s);
    int n = 0;
    sv[d] = 1'b1;
    si[d] = s;
    @(negedge clk);
    while (!sr[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!sr[d]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d got ready=0 want 1", d);
    end
    @(posedge clk);
    #1;
    sv[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && stv[0] && str[0]) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0_extra got %h want none", ds[0]);
      end else begin
        chk("dut0_win", ds[0], q0.pop_front());
        pops0++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && stv[1] && str[1]) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_extra got %h want none", ds[1]);
      end else begin
        chk("dut1_win", ds[1], q1.pop_front());
        pops1++;
      end
    end
  end

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      sv[d]  = 1'b0;
      fl[d]  = 1'b0;
      str[d] = 1'b1;
      si[d]  = 8'h00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid0", stv[0], 0);
    chk("rst_data0", ds[0], 0);
    chk("rst_fill0", fc[0], 0);
    chk("rst_ready0", sr[0], 1);
    chk("rst_valid1", stv[1], 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // block mode on the STRIDE=8 instance
    for (int i = 1; i <= 16; i++) begin
      if (i == 8)  q1.push_back(64'h0102030405060708);
      if (i == 16) q1.push_back(64'h090A0B0C0D0E0F10);
      send(1, 8'(i));
      if (i == 15) begin
        chk("blk_fill15", fc[1], 8);
        chk("blk_quiet15", stv[1], 0);
      end
    end

    // fill and slide
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) q0.push_back(64'h0102030405060708);
      send(0, 8'(i));
    end
    chk("fill_count8", fc[0], 8);
    chk("fill_valid", stv[0], 1);
    chk("fill_data", ds[0], 64'h0102030405060708);
    q0.push_back(64'h0203040506070809);
    send(0, 8'h09);
    chk("slide_data", ds[0], 64'h0203040506070809);

    // backpressure
    str[0] = 1'b0;
    sv[0]  = 1'b1;
    si[0]  = 8'hAA;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", sr[0], 0);
      chk("bp_hold", ds[0], 64'h0203040506070809);
    end
    @(posedge clk);
    #1 str[0] = 1'b1;
    #1 chk("bp_release_ready", sr[0], 1);
    q0.push_back(64'h03040506070809AA);
    send(0, 8'hAA);
    chk("bp_new_win", ds[0], 64'h03040506070809AA);
    str[0] = 1'b0;

    // flush with a pending window
    fl[0] = 1'b1;
    #1 chk("flush_ready", sr[0], 0);
    @(posedge clk);
    #1 fl[0] = 1'b0;
    chk("flush_fill", fc[0], 0);
    chk("flush_keep_valid", stv[0], 1);
    chk("flush_keep_data", ds[0], 64'h03040506070809AA);
    send(0, 8'h11);
    send(0, 8'h12);
    send(0, 8'h13);
    chk("partial_fill3", fc[0], 3);
    fl[0] = 1'b1;
    @(posedge clk);
    #1 fl[0] = 1'b0;
    chk("flush2_fill", fc[0], 0);
    str[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) q0.push_back(64'h2122232425262728);
      send(0, 8'(8'h21 + i));
    end

    // idle gaps between accepted samples
    @(posedge clk);
    #1 q0.push_back(64'h2223242526272829);
    send(0, 8'h29);
    @(posedge clk);
    #1 q0.push_back(64'h232425262728292A);
    send(0, 8'h2A);
    @(posedge clk);
    #1;

    // reset mid-operation
    q0.push_back(64'h2425262728292A31);
    send(0, 8'h31);
    str[0] = 1'b0;
    fl[0]  = 1'b1;
    @(posedge clk);
    #1 fl[0] = 1'b0;
    send(0, 8'h41);
    send(0, 8'h42);
    chk("pre_rst_valid", stv[0], 1);
    chk("pre_rst_fill", fc[0], 2);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    q0.delete();
    chk("mid_rst_valid", stv[0], 0);
    chk("mid_rst_data", ds[0], 0);
    chk("mid_rst_fill", fc[0], 0);
    str[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) q0.push_back(64'h5152535455565758);
      send(0, 8'(8'h51 + i));
      if (i == 6) begin
        chk("fresh_quiet", stv[0], 0);
        chk("fresh_fill7", fc[0], 7);
      end
    end
    chk("fresh_data", ds[0], 64'h5152535455565758);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("pops0", pops0, 7);
    chk("pops1", pops1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_window_packer.md
Name: sample_window_packer

Overview:
Producer side of the averaging datapath. It accepts 8-bit samples one at a time over a valid/ready handshake and packs them into a sliding N-sample window. It presents that window as the flat 64-bit `data_stream` word consumed by the running-average block. A new window is emitted every STRIDE accepted samples once the window is full, with downstream backpressure.

Parameters:
- W, 8: bits per sample.
- N, 8: samples per window; data_stream width is N*W (64 at defaults).
- STRIDE, 1: accepted samples between emitted windows once full. Legal range 1..N; 1 gives a sliding window, N gives non-overlapping blocks.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on clk).
- sample_in  input  W  incoming sample.
- sample_valid  input  1  sample_in is valid.
- sample_ready  output  1  packer can accept this cycle.
- flush  input  1  discard partial window; pending output is untouched.
- data_stream  output  N*W  packed window: oldest sample in the MSBs, newest in [W-1:0].
- stream_valid  output  1  data_stream holds an unconsumed window.
- stream_ready  input  1  downstream consumes data_stream this cycle.
- fill_count  output  clog2(N+1)  samples currently held in the window (0..N).

Behaviour:
- Reset (rst=0 at a clk edge): the following all clear, regardless of other inputs; the reset also aborts any partial window or pending output.
  - window register, data_stream, stream_valid, fill_count, stride counter: all 0.
  - State returns to FILL.
- Accept: `acc = sample_valid & sample_ready`.
  - On acc the window shifts left by W.
  - sample_in enters [W-1:0]; the oldest sample drops out.
- State machine:
  - FILL (fill_count<N):
    - Each acc increments fill_count.
    - The acc that makes fill_count=N emits and moves to RUN with stride_cnt=0.
  - RUN (fill_count=N):
    - Each acc increments stride_cnt.
    - When the acc brings stride_cnt to STRIDE, it emits and resets stride_cnt to 0.
    - With STRIDE=1, every acc emits.
- Emit: data_stream <= the post-shift window, stream_valid <= 1, in the same edge as the accepting sample. Latency is 1 clock from the accepted sample to the visible window.
- Output handshake:
  - stream_valid clears on an edge where stream_ready=1, unless a new emit happens in the same edge (then it stays 1 with new data).
  - data_stream is held stable while stream_valid=1 and stream_ready=0.
- sample_ready:
  - Equals `!flush & !(stream_valid & !stream_ready & emit_next)`, where emit_next means the next acc would emit.
  - It is combinational from stream_ready.
  - Non-emitting samples are still accepted while output is stalled, so no window is ever overwritten unconsumed.
- Flush:
  - On an edge with flush=1, the window is zeroed, fill_count=0, stride_cnt=0, state goes to FILL.
  - sample_ready is 0 that cycle, so no sample is lost silently.
  - stream_valid and data_stream are unaffected.
- Simultaneous stream_ready and emit: the new window replaces the old one; stream_valid stays 1.
- No arithmetic wrap: fill_count saturates at N by construction, and stride_cnt ranges 0..STRIDE-1.

Decomposition:
- Package `avg_stream_pkg`: localparams W_DEF=8 and N_DEF=8, the width function for fill_count, and the FILL/RUN state encoding shared with the running-average block.
- One sub-module, `sample_shift_window`: N-deep by W shift register with a shift-enable and a synchronous clear. It is reused later by the averager. The handshake, counters and FSM live in the top level.

Test Plan:
- Fill and sliding (defaults, STRIDE=1, stream_ready=1):
  - Accept 0x01..0x08 → stream_valid first rises one clock after 0x08, with data_stream=0x0102030405060708 and fill_count=8.
  - Then accept 0x09 → data_stream=0x0203040506070809.
- Block mode (STRIDE=8): accept 0x01..0x10 →
  - Exactly two emits: 0x0102030405060708, then 0x090A0B0C0D0E0F10.
  - No window is emitted for samples 9..15.
- Backpressure (STRIDE=1, window full):
  - stream_ready=0 after an emit → sample_ready=0, and data_stream stays stable for 5 cycles.
  - Raise stream_ready with sample_valid=1 and sample 0xAA → sample_ready rises in that same cycle (combinational from stream_ready); the sample is accepted and the new window ends in 0xAA.
- Flush mid-fill: accept 3 samples, pulse flush → fill_count=0; the next 8 samples alone form the emitted window; a pending window held before the flush is still delivered intact.
- Reset mid-operation: drive rst=0 for one edge while stream_valid=1 and the window is partial → stream_valid=0, data_stream=0, fill_count=0; the next emit needs 8 fresh samples.
- Idle gaps: sample_valid toggles 1010… → windows match the gap-free case; only accepted samples count.
